// File: rtl/alt_eyemon_phase_stepper.sv
// Eye-monitor phase stepper: walks the linear phase one step per write/readback bus transaction to i_target, settling between steps.
// Requests hold until i_ack (bounded by TIMEOUT_CYCLES); readback verify is built only with `define ALT_EYEMON_READBACK_EN.
module alt_eyemon_phase_stepper #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [5:0] i_target,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [5:0] o_cur_phase,
    output logic       o_wr_req,
    output logic       o_rd_req,
    output logic [5:0] o_wr_code,
    input  logic [5:0] i_rd_code,
    input  logic       i_ack
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1) + 1;
    localparam logic [CW-1:0] TMO_LAST    = (TIMEOUT_CYCLES > 1) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_CYCLES > 1) ? CW'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        WR,
`ifdef ALT_EYEMON_READBACK_EN
        RD,
        CHECK,
`endif
        SETTLE,
        ERR
    } state_t;

    // Linear phase to hardware code: the delay line is folded in four 16-step segments.
    function automatic logic [5:0] f_fwd(input logic [5:0] l);
        case (l[5:4])
            2'b00:   f_fwd = 6'd63 - l;
            2'b01:   f_fwd = l;
            2'b10:   f_fwd = 6'd47 - l;
            default: f_fwd = l - 6'd16;
        endcase
    endfunction

`ifdef ALT_EYEMON_READBACK_EN
    function automatic logic [5:0] f_inv(input logic [5:0] c);
        case (c[5:4])
            2'b00:   f_inv = 6'd47 - c;
            2'b01:   f_inv = c;
            2'b10:   f_inv = c + 6'd16;
            default: f_inv = 6'd63 - c;
        endcase
    endfunction
`endif

    state_t          r_state, w_state_nxt;
    logic [5:0]      r_target, w_target_nxt;
    logic [5:0]      r_next, w_next_nxt;
    logic [5:0]      r_cur_phase, w_cur_phase_nxt;
    logic [5:0]      r_wr_code, w_wr_code_nxt;
    logic            r_wr_req, w_wr_req_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_error, w_error_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [5:0]      w_step;

`ifdef ALT_EYEMON_READBACK_EN
    logic            r_rd_req, w_rd_req_nxt;
    logic [5:0]      r_rd_cap, w_rd_cap_nxt;
`else
    logic            w_unused_rd;
    assign w_unused_rd = ^i_rd_code;
`endif

    // STEP only uses this when target != current, so it can never wrap.
    assign w_step = (r_target > r_cur_phase) ? r_cur_phase + 6'd1 : r_cur_phase - 6'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_target_nxt    = r_target;
        w_next_nxt      = r_next;
        w_cur_phase_nxt = r_cur_phase;
        w_wr_code_nxt   = r_wr_code;
        w_wr_req_nxt    = r_wr_req;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_error_nxt     = r_error;
        w_cnt_nxt       = r_cnt;
`ifdef ALT_EYEMON_READBACK_EN
        w_rd_req_nxt    = r_rd_req;
        w_rd_cap_nxt    = r_rd_cap;
`endif
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_target_nxt = i_target;
                    w_busy_nxt   = 1'b1;
                    w_error_nxt  = 1'b0;
                    w_state_nxt  = STEP;
                end
            end
            STEP: begin
                if (r_cur_phase == r_target) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_next_nxt    = w_step;
                    w_wr_code_nxt = f_fwd(w_step);
                    w_wr_req_nxt  = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = WR;
                end
            end
            WR: begin
                if (i_ack) begin
                    w_wr_req_nxt    = 1'b0;
                    w_cur_phase_nxt = r_next;
                    w_cnt_nxt       = '0;
`ifdef ALT_EYEMON_READBACK_EN
                    w_rd_req_nxt    = 1'b1;
                    w_state_nxt     = RD;
`else
                    w_state_nxt     = SETTLE;
`endif
                end else if (r_cnt >= TMO_LAST) begin
                    w_wr_req_nxt = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
`ifdef ALT_EYEMON_READBACK_EN
            RD: begin
                if (i_ack) begin
                    w_rd_req_nxt = 1'b0;
                    w_rd_cap_nxt = i_rd_code;
                    w_state_nxt  = CHECK;
                end else if (r_cnt >= TMO_LAST) begin
                    w_rd_req_nxt = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            CHECK: begin
                if (f_inv(r_rd_cap) == r_cur_phase) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end else begin
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ERR;
                end
            end
`endif
            SETTLE: begin
                if (r_cnt >= SETTLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STEP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ERR: begin
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_target    <= '0;
            r_next      <= '0;
            r_cur_phase <= '0;
            r_wr_code   <= '0;
            r_wr_req    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cnt       <= '0;
`ifdef ALT_EYEMON_READBACK_EN
            r_rd_req    <= 1'b0;
            r_rd_cap    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_next      <= w_next_nxt;
            r_cur_phase <= w_cur_phase_nxt;
            r_wr_code   <= w_wr_code_nxt;
            r_wr_req    <= w_wr_req_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_cnt       <= w_cnt_nxt;
`ifdef ALT_EYEMON_READBACK_EN
            r_rd_req    <= w_rd_req_nxt;
            r_rd_cap    <= w_rd_cap_nxt;
`endif
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_cur_phase = r_cur_phase;
    assign o_wr_req    = r_wr_req;
    assign o_wr_code   = r_wr_code;
`ifdef ALT_EYEMON_READBACK_EN
    assign o_rd_req    = r_rd_req;
`else
    assign o_rd_req    = 1'b0;
`endif

endmodule

// File: doc/alt_eyemon_phase_stepper.md
ALT_EYEMON_PHASE_STEPPER -- requirements
Module: alt_eyemon_phase_stepper

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles waiting for i_ack before error.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: idle cycles after each completed step before the next.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1  one-cycle request to move to i_target.
REQ-006 SHALL have port i_target  input  6  requested linear phase step, 0..63.
REQ-007 SHALL have port o_busy  output  1  high from accepted start until done/error.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse on successful arrival.
REQ-009 SHALL have port o_error  output  1  sticky fault flag.
REQ-010 SHALL have port o_cur_phase  output  6  current linear phase step.
REQ-011 SHALL have port o_wr_req  output  1  hardware phase-code write request.
REQ-012 SHALL have port o_rd_req  output  1  hardware phase-code read request.
REQ-013 SHALL have port o_wr_code  output  6  hardware code to write.
REQ-014 SHALL have port i_rd_code  input  6  hardware code returned; valid when i_ack high during read.
REQ-015 SHALL have port i_ack  input  1  one-cycle completion of the pending read or write.

Function
REQ-016 Forward map linear L to hardware code SHALL be: L 0..15 -> 63-L; 16..31 -> L; 32..47 -> 47-L; 48..63 -> L-16.
REQ-017 Inverse map code C to linear SHALL be: C[5:4]=00 -> 47-C; 01 -> C; 10 -> C+16; 11 -> 63-C; all 6-bit, no overflow.
REQ-018 FSM states SHALL be IDLE, STEP, WR, RD, CHECK, SETTLE, ERR.
REQ-019 IDLE: i_start latches i_target, sets o_busy, clears o_error, goes to STEP next cycle; i_start while o_busy SHALL be ignored.
REQ-020 STEP: if o_cur_phase == target -> pulse o_done, clear o_busy, return IDLE (start with target==current completes in 2 cycles, no bus access); else next = cur+1 if target>cur, cur-1 otherwise, go to WR.
REQ-021 Stepping SHALL be linear by exactly one per transaction, never wrapping 63<->0.
REQ-022 WR: o_wr_req held high with o_wr_code = forward(next) until i_ack; then o_cur_phase <= next and go to RD (or SETTLE per REQ-030).
REQ-023 RD: o_rd_req held high until i_ack; capture i_rd_code, go to CHECK.
REQ-024 CHECK: if inverse(captured) == o_cur_phase go to SETTLE, else go to ERR.
REQ-025 SETTLE: wait SETTLE_CYCLES cycles, then STEP.
REQ-026 o_wr_req and o_rd_req SHALL never be high simultaneously; i_ack outside WR/RD SHALL be ignored.
REQ-027 Timeout counter SHALL reset on WR/RD entry; reaching TIMEOUT_CYCLES without i_ack -> drop request, go to ERR.
REQ-028 ERR: set o_error, clear o_busy, no o_done, return IDLE next cycle; o_error holds until next accepted i_start.

Reset
REQ-029 On i_rst SHALL immediately: state IDLE, o_busy=0, o_done=0, o_error=0, o_wr_req=0, o_rd_req=0, o_wr_code=0, o_cur_phase=0, counters 0; reset mid-transaction abandons it without further requests.

Configuration
REQ-030 Macro ALT_EYEMON_READBACK_EN defined: RD and CHECK included per REQ-022..024; undefined: RD/CHECK omitted, WR proceeds directly to SETTLE, o_rd_req tied 0, i_rd_code unused, mismatch error impossible.

Verification
REQ-031 Reset, i_start target=3, ack each request after 2 cycles, readback echoes written code -> writes codes 62,61,60; o_cur_phase=3; single o_done; o_error=0.
REQ-032 From 3, target=0 -> codes 61,62,63 written in order; o_done; o_cur_phase=0.
REQ-033 From 0, target=0 -> o_done two cycles after i_start; no o_wr_req/o_rd_req.
REQ-034 Readback returns 0x00 for written 0x3E (macro defined) -> o_error=1, o_busy=0, no o_done, o_cur_phase=1.
REQ-035 i_ack never asserted -> after 255 cycles o_wr_req drops, o_error=1; next i_start clears o_error.
REQ-036 i_rst asserted while o_wr_req high -> o_wr_req=0 and all outputs zero immediately, no requests until next i_start.
